alu_ctrl_exec: RTL and testbench

ALU_CTRL_EXEC -- requirements
Module: alu_ctrl_exec

---
 rtl/alu_ctrl_exec_if.sv | 32 +++
 rtl/alu_ctrl_exec.sv | 196 +++++++++++++++++++
 tb/tb_alu_ctrl_exec.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_exec_if.sv
// Request/response bundle for the ALU control and execute block.
// Requester drives the master side; the execute unit sits on the slave side.
interface alu_ctrl_exec_if #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
);
  logic              valid_in;
  logic              ready;
  logic [1:0]        alu_op;
  logic [FUNC_W-1:0] func_op;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic              valid_out;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic [3:0]        alu_control_sig;
  logic              illegal;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output valid_in, alu_op, func_op, operand_a, operand_b,
    input  ready, valid_out, result, zero, alu_control_sig,
    input  illegal, hi, lo
  );

  modport slave (
    input  valid_in, alu_op, func_op, operand_a, operand_b,
    output ready, valid_out, result, zero, alu_control_sig,
    output illegal, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// ALU control decode plus execute: single-cycle ops and an iterative
// shift-add multiplier writing the HI/LO register pair.
module alu_ctrl_exec #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_exec_if.slave bus
);
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_MUL  = 4'b1001;
  localparam logic [3:0] C_MULU = 4'b1010;
  localparam logic [3:0] C_MFHI = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MFLO = 4'b1101;
  localparam logic [3:0] C_ILL  = 4'b1111;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_step, prod_fin;
  logic               neg_q;
  logic [3:0]         mctrl_q;

  logic               vout_q, zero_q, ill_q;
  logic [WIDTH-1:0]   res_q, hi_q, lo_q;
  logic [3:0]         ctrl_q;

  logic [5:0]         func6;
  logic               func_hi_set;
  logic [3:0]         ctrl;
  logic               bad, is_mul, sgn, neg, accept;
  logic [WIDTH-1:0]   a, b, mag_a, mag_b, alu_res;
  logic [WIDTH:0]     sum;

  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign func6  = bus.func_op[5:0];
  assign accept = bus.valid_in && (state_q == IDLE);

  if (FUNC_W > 6) begin : g_fhi
    assign func_hi_set = |bus.func_op[FUNC_W-1:6];
  end else begin : g_nofhi
    assign func_hi_set = 1'b0;
  end

  always_comb begin
    ctrl = C_ADD;
    bad  = 1'b0;
    case (bus.alu_op)
      2'b00: ctrl = C_ADD;
      2'b01: ctrl = C_SUB;
      2'b11: ctrl = C_OR;
      default: begin
        case (func6)
          6'b100000, 6'b100001: ctrl = C_ADD;
          6'b100010, 6'b100011: ctrl = C_SUB;
          6'b100100: ctrl = C_AND;
          6'b100101: ctrl = C_OR;
          6'b100110: ctrl = C_XOR;
          6'b100111: ctrl = C_NOR;
          6'b101010: ctrl = C_SLT;
          6'b101011: ctrl = C_SLTU;
          6'b011000: ctrl = C_MUL;
          6'b011001: ctrl = C_MULU;
          6'b010000: ctrl = C_MFHI;
          6'b010010: ctrl = C_MFLO;
          default: begin
            ctrl = C_ILL;
            bad  = 1'b1;
          end
        endcase
        if (func_hi_set) begin
          ctrl = C_ILL;
          bad  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ctrl)
      C_ADD:  alu_res = a + b;
      C_SUB:  alu_res = a - b;
      C_AND:  alu_res = a & b;
      C_OR:   alu_res = a | b;
      C_XOR:  alu_res = a ^ b;
      C_NOR:  alu_res = ~(a | b);
      C_SLT:  alu_res[0] = $signed(a) < $signed(b);
      C_SLTU: alu_res[0] = a < b;
      C_MFHI: alu_res = hi_q;
      C_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Most-negative operand negates to itself, which is its correct
  // unsigned magnitude, so no special case is needed.
  assign is_mul = (ctrl == C_MUL) || (ctrl == C_MULU);
  assign sgn    = (ctrl == C_MUL);
  assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign neg    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);

  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
        + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};
    prod_fin  = neg_q ? -prod_q : prod_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ctrl_q  <= 4'b0000;
      ill_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      mctrl_q <= 4'b0000;
    end else begin
      vout_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (is_mul) begin
            mcand_q <= mag_a;
            prod_q  <= {{WIDTH{1'b0}}, mag_b};
            neg_q   <= neg;
            mctrl_q <= ctrl;
            cnt_q   <= '0;
          end else begin
            vout_q <= 1'b1;
            res_q  <= alu_res;
            zero_q <= (alu_res == '0);
            ctrl_q <= ctrl;
            ill_q  <= bad;
          end
        end
        MUL: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q + 1'b1;
        end
        DONE: begin
          hi_q   <= prod_fin[2*WIDTH-1:WIDTH];
          lo_q   <= prod_fin[WIDTH-1:0];
          res_q  <= prod_fin[WIDTH-1:0];
          zero_q <= (prod_fin[WIDTH-1:0] == '0);
          ctrl_q <= mctrl_q;
          ill_q  <= 1'b0;
          vout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready           = (state_q == IDLE);
  assign bus.valid_out       = vout_q;
  assign bus.result          = res_q;
  assign bus.zero            = zero_q;
  assign bus.alu_control_sig = ctrl_q;
  assign bus.illegal         = ill_q;
  assign bus.hi              = hi_q;
  assign bus.lo              = lo_q;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Randomized check of alu_ctrl_exec against a behavioural model using
// native arithmetic for ALU ops and full-width products for multiplies.
module tb_alu_ctrl_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] last_r = '0;

  alu_ctrl_exec_if #(.WIDTH(32), .FUNC_W(6)) bus ();

  alu_ctrl_exec #(.WIDTH(32), .FUNC_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] c, output logic [31:0] r,
                           output bit ill, output bit mul,
                           output logic [63:0] p);
    longint sa, sb;
    ill = 0; mul = 0; r = '0; p = '0; c = 4'd2;
    case (op)
      2'b00: begin c = 4'b0010; r = a + b; end
      2'b01: begin c = 4'b0110; r = a - b; end
      2'b11: begin c = 4'b0001; r = a | b; end
      default: begin
        case (fn)
          6'h20, 6'h21: begin c = 4'b0010; r = a + b; end
          6'h22, 6'h23: begin c = 4'b0110; r = a - b; end
          6'h24: begin c = 4'b0000; r = a & b; end
          6'h25: begin c = 4'b0001; r = a | b; end
          6'h26: begin c = 4'b0011; r = a ^ b; end
          6'h27: begin c = 4'b1100; r = ~(a | b); end
          6'h2a: begin c = 4'b0111; r = ($signed(a) < $signed(b)) ? 1 : 0; end
          6'h2b: begin c = 4'b1000; r = (a < b) ? 1 : 0; end
          6'h18: begin
            c = 4'b1001; mul = 1;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p = 64'(sa * sb);
            r = p[31:0];
          end
          6'h19: begin
            c = 4'b1010; mul = 1;
            p = {32'b0, a} * {32'b0, b};
            r = p[31:0];
          end
          6'h10: begin c = 4'b1011; r = exp_hi; end
          6'h12: begin c = 4'b1101; r = exp_lo; end
          default: begin c = 4'b1111; ill = 1; r = '0; end
        endcase
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    logic [3:0] c;
    logic [31:0] r;
    logic [63:0] p;
    bit ill, mul;
    int lat, busy;
    ref_model(op, fn, a, b, c, r, ill, mul, p);
    chk("ready_at_issue", bus.ready, 1);
    bus.alu_op = op; bus.func_op = fn;
    bus.operand_a = a; bus.operand_b = b;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    if (mul) begin
      lat = 0; busy = 0;
      while (!bus.valid_out && lat < 60) begin
        if (!bus.ready) busy++;
        bus.valid_in  = 1'($urandom_range(0, 1));
        bus.alu_op    = 2'($urandom);
        bus.func_op   = 6'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        @(negedge clk);
        lat++;
      end
      bus.valid_in = 1'b0;
      chk("mul_latency", lat, 33);
      chk("mul_busy_cycles", busy, 33);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end
    chk("valid_out", bus.valid_out, 1);
    chk("result", bus.result, r);
    chk("zero", bus.zero, (r == 0));
    chk("ctrl", bus.alu_control_sig, c);
    chk("illegal", bus.illegal, ill);
    chk("hi", bus.hi, exp_hi);
    chk("lo", bus.lo, exp_lo);
    last_r = r;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] fl [14];
    logic [1:0] op;
    logic [5:0] fn;
    int seen;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
           6'h27, 6'h2a, 6'h2b, 6'h18, 6'h19, 6'h10, 6'h12};
    bus.valid_in = 1'b0; bus.alu_op = '0; bus.func_op = '0;
    bus.operand_a = '0; bus.operand_b = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_vout", bus.valid_out, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_ctrl", bus.alu_control_sig, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst = 1'b0;

    do_op(2'b10, 6'h22, 32'd5, 32'd5);
    chk("sub_ctrl", bus.alu_control_sig, 4'b0110);
    chk("sub_zero", bus.zero, 1);
    do_op(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg", bus.result, 1);
    do_op(2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_big", bus.result, 0);
    do_op(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    do_op(2'b10, 6'h10, 32'd0, 32'd0);
    chk("mfhi_after_mult", bus.result, 32'hFFFF_FFFF);
    do_op(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    @(negedge clk);
    chk("multu_single_pulse", bus.valid_out, 0);
    do_op(2'b10, 6'h18, 32'h8000_0000, 32'h8000_0000);
    chk("mult_minneg_hi", bus.hi, 32'h4000_0000);
    do_op(2'b10, 6'h3f, 32'd7, 32'd9);
    chk("ill_ctrl", bus.alu_control_sig, 4'b1111);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_hi_kept", bus.hi, 32'h4000_0000);

    // abort a multiply ten cycles in
    bus.alu_op = 2'b10; bus.func_op = 6'h18;
    bus.operand_a = 32'd1234; bus.operand_b = 32'd5678;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_vout", bus.valid_out, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_ctrl", bus.alu_control_sig, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_out) seen++;
    end
    chk("abort_no_vout", seen, 0);
    chk("abort_lo_zero", bus.lo, 0);

    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom);
      if ($urandom_range(0, 3) != 0) op = 2'b10;
      fn = fl[$urandom_range(0, 13)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      do_op(op, fn, rnd_val(), rnd_val());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("vout_drop", bus.valid_out, 0);
        chk("result_hold", bus.result, last_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
